// File: rtl/lzw_string_regs.sv
// LZW working-string, code and pointer registers with a dictionary entry writer.
// The live string, next free code and dictionary pointers are updated by single
// cycle commands. On WrStart the writer snapshots the string, its size and the
// code, then streams a header word and the packed character words to RAM over
// a valid/ready handshake before advancing InsertPointer past the new entry.
// Optional build macro: LZW_OVF_DETECT_EN enables the sticky StrOverflow flag.
module lzw_string_regs #(
  parameter int unsigned CHAR_W    = 8,
  parameter int unsigned MAX_CHARS = 15,
  parameter int unsigned CODE_W    = 12,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned RAM_W     = 16
) (
  input  logic                               Clock,
  input  logic                               Reset_n,
  input  logic [CHAR_W-1:0]                  CharIn,
  input  logic                               StrClear,
  input  logic                               StrLoad,
  input  logic                               StrAppend,
  input  logic                               StrDrop,
  output logic [MAX_CHARS*CHAR_W-1:0]        String,
  output logic [$clog2(MAX_CHARS+1)-1:0]     StringSize,
  output logic                               StrFull,
  output logic                               StrOverflow,
  input  logic                               CodeClear,
  input  logic                               CodeIncrement,
  output logic [CODE_W-1:0]                  Code,
  output logic                               CodeFull,
  input  logic [ADDR_W-1:0]                  PtrInit,
  input  logic                               PtrLoad,
  input  logic                               PtrInc,
  input  logic                               PtrJump,
  input  logic                               SetJump,
  input  logic                               InsLoad,
  input  logic [RAM_W-1:0]                   HdrIn,
  output logic [ADDR_W-1:0]                  DicPointer,
  output logic [ADDR_W-1:0]                  JumpAddress,
  output logic [ADDR_W-1:0]                  InsertPointer,
  input  logic                               WrStart,
  output logic [ADDR_W-1:0]                  RamAddr,
  output logic [RAM_W-1:0]                   RamData,
  output logic                               RamValid,
  input  logic                               RamReady,
  output logic                               WrBusy,
  output logic                               WrDone
);

  localparam int unsigned SIZE_W = $clog2(MAX_CHARS + 1);
  localparam int unsigned CPW    = RAM_W / CHAR_W;
  localparam int unsigned STR_W  = MAX_CHARS * CHAR_W;
  localparam int unsigned NWORDS = (MAX_CHARS + CPW - 1) / CPW;
  localparam int unsigned SNAP_W = NWORDS * RAM_W;
  localparam int unsigned WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned WCNT_W = $clog2(NWORDS + 1);

  // Parameter sanity: characters must tile a RAM word and the header must fit
  if ((RAM_W % CHAR_W) != 0) begin : gChkCharW
    $error("lzw_string_regs: RAM_W must be a multiple of CHAR_W");
  end
  if ((SIZE_W + CODE_W) > RAM_W) begin : gChkHdr
    $error("lzw_string_regs: SIZE_W + CODE_W exceeds RAM_W");
  end

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} wrState_t;

  // Number of RAM words needed to hold sz characters
  function automatic logic [WCNT_W-1:0] wordsOf(input logic [SIZE_W-1:0] sz);
    return WCNT_W'((32'(sz) + CPW - 1) / CPW);
  endfunction

  logic [STR_W-1:0]  strNext;
  logic [SIZE_W-1:0] sizeNext;
  logic [CODE_W-1:0] codeNext;
  logic [SIZE_W-1:0] hdrSize;
  logic [ADDR_W-1:0] hdrWords;
  logic              unusedHdr;

  wrState_t          state;
  wrState_t          stateNext;
  logic [SNAP_W-1:0] snapStr;
  logic [WCNT_W-1:0] snapWords;
  logic [ADDR_W-1:0] base;
  logic [WIDX_W-1:0] wordIdx;
  logic [WIDX_W-1:0] wordIdxNext;
  logic [WIDX_W-1:0] selIdx;
  logic [RAM_W-1:0]  selWord;
  logic              snapLoad;
  logic              ramValidNext;
  logic [ADDR_W-1:0] ramAddrNext;
  logic [RAM_W-1:0]  ramDataNext;
  logic              wrDoneNext;

  // Next live string: clear > load > append > drop; chars above size stay zero
  always_comb begin
    strNext  = String;
    sizeNext = StringSize;
    if (StrClear) begin
      strNext  = '0;
      sizeNext = '0;
    end else if (StrLoad) begin
      strNext             = '0;
      strNext[0+:CHAR_W]  = CharIn;
      sizeNext            = SIZE_W'(1);
    end else if (StrAppend) begin
      if (!StrFull) begin
        for (int i = 0; i < int'(MAX_CHARS); i++) begin
          if (StringSize == SIZE_W'(i)) strNext[i*CHAR_W +: CHAR_W] = CharIn;
        end
        sizeNext = StringSize + SIZE_W'(1);
      end
    end else if (StrDrop) begin
      if (StringSize != '0) begin
        for (int i = 0; i < int'(MAX_CHARS); i++) begin
          if (StringSize == SIZE_W'(i + 1)) strNext[i*CHAR_W +: CHAR_W] = '0;
        end
        sizeNext = StringSize - SIZE_W'(1);
      end
    end
  end

  // Live string registers with registered full flag
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      String     <= '0;
      StringSize <= '0;
      StrFull    <= 1'b0;
    end else begin
      String     <= strNext;
      StringSize <= sizeNext;
      StrFull    <= (sizeNext == SIZE_W'(MAX_CHARS));
    end
  end

`ifdef LZW_OVF_DETECT_EN
  // Sticky overflow: set by an effective append at full, cleared by StrClear
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      StrOverflow <= 1'b0;
    end else if (StrClear) begin
      StrOverflow <= 1'b0;
    end else if (!StrLoad && StrAppend && StrFull) begin
      StrOverflow <= 1'b1;
    end
  end
`else
  assign StrOverflow = 1'b0;
`endif

  // Next free code: clear > increment, saturating at all ones
  always_comb begin
    codeNext = Code;
    if (CodeClear) begin
      codeNext = '0;
    end else if (CodeIncrement && !CodeFull) begin
      codeNext = Code + CODE_W'(1);
    end
  end

  // Code register with registered saturation flag
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Code     <= '0;
      CodeFull <= 1'b0;
    end else begin
      Code     <= codeNext;
      CodeFull <= &codeNext;
    end
  end

  // Size field of the header word under DicPointer, rounded up to whole words
  assign hdrSize   = HdrIn[CODE_W +: SIZE_W];
  assign hdrWords  = ADDR_W'((32'(hdrSize) + CPW - 1) / CPW);
  assign unusedHdr = ^HdrIn;

  // Dictionary walk pointer and precomputed jump past the current entry
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      DicPointer  <= '0;
      JumpAddress <= '0;
    end else begin
      if (PtrLoad) begin
        DicPointer <= PtrInit;
      end else if (PtrInc) begin
        DicPointer <= DicPointer + ADDR_W'(1);
      end else if (PtrJump) begin
        DicPointer <= JumpAddress;
      end
      if (SetJump) begin
        JumpAddress <= DicPointer + ADDR_W'(1) + hdrWords;
      end
    end
  end

  // Insert pointer: advanced past a finished entry, else loadable while idle
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      InsertPointer <= '0;
    end else if (state == DONE) begin
      InsertPointer <= base + ADDR_W'(1) + ADDR_W'(snapWords);
    end else if (InsLoad && !WrBusy) begin
      InsertPointer <= DicPointer;
    end
  end

  // Select the snapshot word the writer presents next
  always_comb begin
    selIdx  = (state == HDR) ? '0 : wordIdx + WIDX_W'(1);
    selWord = '0;
    for (int k = 0; k < int'(NWORDS); k++) begin
      if (selIdx == WIDX_W'(k)) selWord = snapStr[k*RAM_W +: RAM_W];
    end
  end

  // Writer next-state and next-output logic
  always_comb begin
    stateNext    = state;
    ramValidNext = RamValid;
    ramAddrNext  = RamAddr;
    ramDataNext  = RamData;
    wrDoneNext   = 1'b0;
    wordIdxNext  = wordIdx;
    snapLoad     = 1'b0;
    unique case (state)
      IDLE: begin
        if (WrStart) begin
          snapLoad     = 1'b1;
          stateNext    = HDR;
          ramValidNext = 1'b1;
          ramAddrNext  = InsertPointer;
          ramDataNext  = RAM_W'({StringSize, Code});
        end
      end
      HDR: begin
        if (RamReady) begin
          if (snapWords == '0) begin
            stateNext    = DONE;
            ramValidNext = 1'b0;
            wrDoneNext   = 1'b1;
          end else begin
            stateNext   = DATA;
            ramAddrNext = base + ADDR_W'(1);
            ramDataNext = selWord;
            wordIdxNext = '0;
          end
        end
      end
      DATA: begin
        if (RamReady) begin
          if ((WCNT_W'(wordIdx) + WCNT_W'(1)) == snapWords) begin
            stateNext    = DONE;
            ramValidNext = 1'b0;
            wrDoneNext   = 1'b1;
          end else begin
            wordIdxNext = wordIdx + WIDX_W'(1);
            ramAddrNext = RamAddr + ADDR_W'(1);
            ramDataNext = selWord;
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Writer state register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Writer snapshot and registered RAM-side outputs
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      snapStr   <= '0;
      snapWords <= '0;
      base      <= '0;
      wordIdx   <= '0;
      RamValid  <= 1'b0;
      RamAddr   <= '0;
      RamData   <= '0;
      WrBusy    <= 1'b0;
      WrDone    <= 1'b0;
    end else begin
      if (snapLoad) begin
        snapStr   <= SNAP_W'(String);
        snapWords <= wordsOf(StringSize);
        base      <= InsertPointer;
      end
      wordIdx  <= wordIdxNext;
      RamValid <= ramValidNext;
      RamAddr  <= ramAddrNext;
      RamData  <= ramDataNext;
      WrBusy   <= (stateNext != IDLE);
      WrDone   <= wrDoneNext;
    end
  end

endmodule

// File: tb/tb_lzw_string_regs.sv
// Bench for lzw_string_regs: a vector table for the string/code commands,
// hand sequences for writes, stalls, saturation, overflow, jump and reset,
// and random traffic against a queue-based model of the string, code,
// pointers and the expected RAM entry.
module tb_lzw_string_regs;

  localparam int CHAR_W = 8, MAX_CHARS = 15, CODE_W = 12, ADDR_W = 18, RAM_W = 16;
  localparam int CODE_MAX = 4095;

  logic Clock = 1'b0;
  logic Reset_n;
  logic [7:0] CharIn;
  logic StrClear, StrLoad, StrAppend, StrDrop;
  logic [119:0] String;
  logic [3:0] StringSize;
  logic StrFull, StrOverflow;
  logic CodeClear, CodeIncrement;
  logic [11:0] Code;
  logic CodeFull;
  logic [17:0] PtrInit;
  logic PtrLoad, PtrInc, PtrJump, SetJump, InsLoad;
  logic [15:0] HdrIn;
  logic [17:0] DicPointer, JumpAddress, InsertPointer;
  logic WrStart;
  logic [17:0] RamAddr;
  logic [15:0] RamData;
  logic RamValid, RamReady, WrBusy, WrDone;

  lzw_string_regs #(.CHAR_W(CHAR_W), .MAX_CHARS(MAX_CHARS), .CODE_W(CODE_W),
                    .ADDR_W(ADDR_W), .RAM_W(RAM_W)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .CharIn(CharIn),
    .StrClear(StrClear), .StrLoad(StrLoad), .StrAppend(StrAppend), .StrDrop(StrDrop),
    .String(String), .StringSize(StringSize), .StrFull(StrFull), .StrOverflow(StrOverflow),
    .CodeClear(CodeClear), .CodeIncrement(CodeIncrement), .Code(Code), .CodeFull(CodeFull),
    .PtrInit(PtrInit), .PtrLoad(PtrLoad), .PtrInc(PtrInc), .PtrJump(PtrJump),
    .SetJump(SetJump), .InsLoad(InsLoad), .HdrIn(HdrIn),
    .DicPointer(DicPointer), .JumpAddress(JumpAddress), .InsertPointer(InsertPointer),
    .WrStart(WrStart), .RamAddr(RamAddr), .RamData(RamData), .RamValid(RamValid),
    .RamReady(RamReady), .WrBusy(WrBusy), .WrDone(WrDone)
  );

  always #5 Clock = ~Clock;

  int nVec = 0;
  int nErr = 0;

  // Reference model state
  logic [7:0]  mStr[$];
  int          mCode;
  logic [17:0] mDic, mJump, mIns;
  bit          mOvf;
  logic [17:0] capA[$];
  logic [15:0] capD[$];

  typedef struct {
    bit clr, ld, app, drp;
    logic [7:0] ch;
    bit cclr, cinc;
    int eSize;
    logic [31:0] eLow;
    int eCode;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  task automatic clearCmds();
    CharIn = '0; StrClear = 0; StrLoad = 0; StrAppend = 0; StrDrop = 0;
    CodeClear = 0; CodeIncrement = 0; PtrLoad = 0; PtrInc = 0; PtrJump = 0;
    SetJump = 0; InsLoad = 0; WrStart = 0;
  endtask

  task automatic randCmds();
    CharIn = 8'($urandom); StrClear = pct(4); StrLoad = pct(8); StrAppend = pct(45);
    StrDrop = pct(20); CodeClear = pct(3); CodeIncrement = pct(30);
    PtrInit = 18'($urandom); PtrLoad = pct(8); PtrInc = pct(20); PtrJump = pct(10);
    SetJump = pct(15); HdrIn = 16'($urandom); InsLoad = pct(15);
  endtask

  task automatic modelReset();
    mStr.delete(); mCode = 0; mDic = '0; mJump = '0; mIns = '0; mOvf = 0;
  endtask

  // Apply the command inputs present at a clock edge to the model
  task automatic modelStep(input bit busy);
    logic [17:0] nd, nj, ni;
    int hs;
    if (StrClear) begin mStr.delete(); mOvf = 0; end
    else if (StrLoad) begin mStr.delete(); mStr.push_back(CharIn); end
    else if (StrAppend) begin
      if (mStr.size() == MAX_CHARS) mOvf = 1; else mStr.push_back(CharIn);
    end else if (StrDrop) begin
      if (mStr.size() > 0) void'(mStr.pop_back());
    end
    if (CodeClear) mCode = 0;
    else if (CodeIncrement && mCode != CODE_MAX) mCode++;
    nd = mDic; nj = mJump; ni = mIns;
    if (PtrLoad) nd = PtrInit;
    else if (PtrInc) nd = mDic + 18'd1;
    else if (PtrJump) nd = mJump;
    hs = int'(HdrIn[15:12]);
    if (SetJump) nj = mDic + 18'd1 + 18'((hs + 1) / 2);
    if (InsLoad && !busy) ni = mDic;
    mDic = nd; mJump = nj; mIns = ni;
  endtask

  task automatic tick(input bit busy);
    @(posedge Clock);
    modelStep(busy);
    #1;
  endtask

  function automatic logic [119:0] expString();
    logic [119:0] e = '0;
    for (int i = 0; i < mStr.size(); i++) e[i*8 +: 8] = mStr[i];
    return e;
  endfunction

  task automatic checkRegs();
    chk("String", String, expString());
    chk("StringSize", StringSize, mStr.size());
    chk("StrFull", StrFull, mStr.size() == MAX_CHARS);
`ifdef LZW_OVF_DETECT_EN
    chk("StrOverflow", StrOverflow, mOvf);
`else
    chk("StrOverflow", StrOverflow, 0);
`endif
    chk("Code", Code, mCode);
    chk("CodeFull", CodeFull, mCode == CODE_MAX);
    chk("DicPointer", DicPointer, mDic);
    chk("JumpAddress", JumpAddress, mJump);
    chk("InsertPointer", InsertPointer, mIns);
  endtask

  task automatic checkZero(input string tag);
    chk({tag, " String"}, String, 0);
    chk({tag, " StringSize"}, StringSize, 0);
    chk({tag, " StrFull"}, StrFull, 0);
    chk({tag, " StrOverflow"}, StrOverflow, 0);
    chk({tag, " Code"}, Code, 0);
    chk({tag, " CodeFull"}, CodeFull, 0);
    chk({tag, " DicPointer"}, DicPointer, 0);
    chk({tag, " JumpAddress"}, JumpAddress, 0);
    chk({tag, " InsertPointer"}, InsertPointer, 0);
    chk({tag, " RamAddr"}, RamAddr, 0);
    chk({tag, " RamData"}, RamData, 0);
    chk({tag, " RamValid"}, RamValid, 0);
    chk({tag, " WrBusy"}, WrBusy, 0);
    chk({tag, " WrDone"}, WrDone, 0);
  endtask

  // One dictionary write; readyPct < 0 selects a fixed three-cycle stall pattern
  task automatic doWrite(input int readyPct, input bit cmds);
    logic [17:0] expA[$];
    logic [15:0] expD[$];
    logic [17:0] base, pA;
    logic [15:0] pD, w;
    int sz, nw, n, cyc;
    bit stalled;
    base = mIns; sz = mStr.size(); nw = (sz + 1) / 2;
    expA.push_back(base);
    expD.push_back(16'((sz << 12) | mCode));
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int c = 0; c < 2; c++) if (2 * k + c < sz) w[c*8 +: 8] = mStr[2*k+c];
      expA.push_back(base + 18'(1 + k));
      expD.push_back(w);
    end
    capA.delete(); capD.delete();
    if (cmds) randCmds(); else clearCmds();
    WrStart = 1; RamReady = 0;
    tick(0);
    WrStart = 0;
    checkRegs();
    n = 0; cyc = 0; stalled = 0; pA = '0; pD = '0;
    while (!WrDone && cyc < 300) begin
      chk("RamValid while busy", RamValid, 1);
      if (stalled) begin
        chk("RamAddr stable", RamAddr, pA);
        chk("RamData stable", RamData, pD);
      end
      pA = RamAddr; pD = RamData;
      if (readyPct < 0) RamReady = !(cyc >= 2 && cyc <= 4);
      else RamReady = pct(readyPct);
      if (cmds) begin randCmds(); WrStart = pct(15); end else clearCmds();
      tick(1);
      cyc++;
      if (RamReady) begin
        capA.push_back(pA); capD.push_back(pD);
        if (n < expA.size()) begin
          chk($sformatf("word%0d addr", n), pA, expA[n]);
          chk($sformatf("word%0d data", n), pD, expD[n]);
        end else begin
          chk("extra word", n + 1, expA.size());
        end
        n++;
        stalled = 0;
      end else begin
        stalled = 1;
      end
      checkRegs();
    end
    if (!WrDone) chk("WrDone timeout", WrDone, 1);
    chk("words written", n, expA.size());
    chk("RamValid in done", RamValid, 0);
    chk("WrBusy in done", WrBusy, 1);
    clearCmds(); RamReady = 0;
    tick(1);
    mIns = base + 18'(1 + nw);
    chk("WrDone one cycle", WrDone, 0);
    chk("WrBusy idle", WrBusy, 0);
    checkRegs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{0, 1, 0, 0, 8'h41, 0, 1, 1, 32'h41, 1};
    tbl[1]  = '{0, 0, 1, 0, 8'h42, 0, 0, 2, 32'h4241, 1};
    tbl[2]  = '{0, 0, 1, 0, 8'h43, 0, 1, 3, 32'h434241, 2};
    tbl[3]  = '{0, 0, 0, 1, 8'h00, 0, 0, 2, 32'h4241, 2};
    tbl[4]  = '{1, 1, 1, 0, 8'h55, 1, 1, 0, 32'h0, 0};
    tbl[5]  = '{0, 0, 0, 1, 8'h00, 0, 0, 0, 32'h0, 0};
    tbl[6]  = '{0, 1, 1, 0, 8'h61, 0, 1, 1, 32'h61, 1};
    tbl[7]  = '{0, 0, 1, 1, 8'h62, 0, 1, 2, 32'h6261, 2};
    tbl[8]  = '{0, 0, 1, 0, 8'h63, 0, 0, 3, 32'h636261, 2};
    tbl[9]  = '{0, 0, 1, 0, 8'h64, 0, 0, 4, 32'h64636261, 2};
    tbl[10] = '{0, 0, 0, 1, 8'h00, 0, 0, 3, 32'h636261, 2};
    tbl[11] = '{0, 1, 0, 0, 8'h7A, 1, 0, 1, 32'h7A, 0};

    clearCmds(); PtrInit = '0; HdrIn = '0; RamReady = 0;
    Reset_n = 0;
    modelReset();
    @(posedge Clock); @(posedge Clock); #1;
    checkZero("reset");
    @(negedge Clock); Reset_n = 1;

    // String/code command table
    for (int i = 0; i < 12; i++) begin
      clearCmds();
      StrClear = tbl[i].clr; StrLoad = tbl[i].ld; StrAppend = tbl[i].app;
      StrDrop = tbl[i].drp; CharIn = tbl[i].ch;
      CodeClear = tbl[i].cclr; CodeIncrement = tbl[i].cinc;
      tick(0);
      chk($sformatf("vec%0d size", i), StringSize, tbl[i].eSize);
      chk($sformatf("vec%0d string", i), String, {88'b0, tbl[i].eLow});
      chk($sformatf("vec%0d code", i), Code, tbl[i].eCode);
      checkRegs();
    end

    // Fill to capacity, then append at full
    clearCmds(); StrLoad = 1; CharIn = 8'h41; tick(0);
    for (int i = 1; i < MAX_CHARS; i++) begin
      clearCmds(); StrAppend = 1; CharIn = 8'(8'h41 + i); tick(0);
    end
    chk("full size", StringSize, 15);
    chk("full flag", StrFull, 1);
    clearCmds(); StrAppend = 1; CharIn = 8'h5A; tick(0);
    chk("append at full size", StringSize, 15);
    chk("append at full top char", String[119:112], 8'h4F);
`ifdef LZW_OVF_DETECT_EN
    chk("overflow set", StrOverflow, 1);
`else
    chk("overflow tied", StrOverflow, 0);
`endif
    checkRegs();
    clearCmds(); StrClear = 1; tick(0);
    chk("overflow cleared", StrOverflow, 0);
    checkRegs();

    // Jump past a 5-character entry
    clearCmds(); PtrInit = 18'h200; PtrLoad = 1; tick(0);
    clearCmds(); HdrIn = 16'h5123; SetJump = 1; tick(0);
    chk("jump address", JumpAddress, 18'h204);
    clearCmds(); PtrJump = 1; tick(0);
    chk("dic after jump", DicPointer, 18'h204);
    checkRegs();

    // Code saturation
    clearCmds(); CodeClear = 1; tick(0);
    clearCmds(); CodeIncrement = 1;
    for (int i = 0; i < CODE_MAX - 1; i++) tick(0);
    chk("code below max", Code, 12'hFFE);
    chk("codefull below max", CodeFull, 0);
    tick(0);
    chk("code at max", Code, 12'hFFF);
    chk("codefull at max", CodeFull, 1);
    tick(0);
    chk("code saturated", Code, 12'hFFF);
    checkRegs();

    // Random command traffic
    for (int i = 0; i < 400; i++) begin
      randCmds(); tick(0); checkRegs();
    end

    // Known entry: code 5, "ABC", base 0x100, always ready
    clearCmds(); StrClear = 1; CodeClear = 1; tick(0);
    clearCmds(); CodeIncrement = 1;
    for (int i = 0; i < 5; i++) tick(0);
    clearCmds(); StrLoad = 1; CharIn = 8'h41; tick(0);
    clearCmds(); StrAppend = 1; CharIn = 8'h42; tick(0);
    clearCmds(); StrAppend = 1; CharIn = 8'h43; tick(0);
    clearCmds(); PtrInit = 18'h100; PtrLoad = 1; tick(0);
    clearCmds(); InsLoad = 1; tick(0);
    checkRegs();
    doWrite(100, 0);
    chk("abc word count", capD.size(), 3);
    if (capD.size() == 3) begin
      chk("abc hdr", {capA[0], capD[0]}, {18'h100, 16'h3005});
      chk("abc w0", {capA[1], capD[1]}, {18'h101, 16'h4241});
      chk("abc w1", {capA[2], capD[2]}, {18'h102, 16'h0043});
    end
    chk("abc insert ptr", InsertPointer, 18'h103);

    // Five characters with RamReady low for three cycles mid-data
    clearCmds(); StrAppend = 1; CharIn = 8'h44; tick(0);
    clearCmds(); StrAppend = 1; CharIn = 8'h45; tick(0);
    doWrite(-1, 0);

    // Random entries with random readiness and live traffic during the write
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < int'($urandom_range(8)); i++) begin
        randCmds(); tick(0); checkRegs();
      end
      doWrite(int'($urandom_range(20, 100)), 1);
    end

    // Reset asserted while the writer is in DATA
    clearCmds(); StrClear = 1; tick(0);
    for (int i = 0; i < 5; i++) begin
      clearCmds(); StrAppend = 1; CharIn = 8'(8'h61 + i); tick(0);
    end
    clearCmds(); WrStart = 1; RamReady = 1; tick(0);
    clearCmds(); tick(1);
    RamReady = 0; tick(1);
    chk("pre-reset busy", WrBusy, 1);
    #2; Reset_n = 0; #1;
    modelReset();
    checkZero("mid-write reset");
    @(posedge Clock); @(negedge Clock);
    Reset_n = 1; RamReady = 1;
    for (int i = 0; i < 5; i++) begin
      tick(0);
      chk("post-reset RamValid", RamValid, 0);
      chk("post-reset WrBusy", WrBusy, 0);
      checkRegs();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
